// File: rtl/writeback_stage_if.sv
// Memory-latch to write-back bundle: destination, control, ALU result, load data.
// master drives the bundle (memory latch / bench), slave consumes it (write-back).
interface writeback_stage_if #(
    parameter int DW = 32
);
    logic [3:0]    rd_in;
    logic [10:0]   sign_in;
    logic [DW-1:0] alu_in;
    logic [DW-1:0] data_in;

    modport master (
        output rd_in,
        output sign_in,
        output alu_in,
        output data_in
    );

    modport slave (
        input rd_in,
        input sign_in,
        input alu_in,
        input data_in
    );
endinterface

// File: rtl/writeback_stage.sv
// Write-back stage: selects the write value, owns the 16x32 register file,
// serves decode's two read ports, drives the execute forwarding tap,
// counts retired instructions and freezes architectural effects on halt.
// Ports: clk, rst_n (sync, active low); mem_i (memory latch bundle, slave);
// rs_a/rs_b -> rdata_a/rdata_b; wb_en/wb_rd/wb_data forwarding tap;
// retired_count; halted.
// Option: define WB_BYPASS_EN to forward the same-cycle write into the
// read ports (write-through); otherwise reads return the old value.
module writeback_stage #(
    parameter int NREG  = 16,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    writeback_stage_if.slave     mem_i,
    input  logic [3:0]           rs_a,
    input  logic [3:0]           rs_b,
    output logic [DW-1:0]        rdata_a,
    output logic [DW-1:0]        rdata_b,
    output logic                 wb_en,
    output logic [3:0]           wb_rd,
    output logic [DW-1:0]        wb_data,
    output logic [CNT_W-1:0]     retired_count,
    output logic                 halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halted_q;
    logic [DW-1:0]       regs_q [NREG];

    logic                reg_write;
    logic                mem_to_reg;
    logic                halt;
    logic                retire;
    logic                unused_ctrl;

    assign reg_write   = mem_i.sign_in[8];
    assign mem_to_reg  = mem_i.sign_in[9];
    assign halt        = mem_i.sign_in[10];
    assign unused_ctrl = ^mem_i.sign_in[7:0];

    // Both ordinary write-backs and the halt itself count as a retire.
    assign retire = reg_write | halt;

    // Forwarding tap; gated by reset so execute never sees a bogus commit.
    assign wb_rd   = mem_i.rd_in;
    assign wb_data = mem_to_reg ? mem_i.data_in : mem_i.alu_in;
    assign wb_en   = rst_n & reg_write & (mem_i.rd_in != 4'd0)
                   & (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            if (retire) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (halt) begin
                state_d = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == HALTED);
        end
    end

    // wb_en already excludes r0, reset and the halted state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[mem_i.rd_in] <= wb_data;
        end
    end

    logic [DW-1:0] rf_a, rf_b;

    assign rf_a = (rs_a == 4'd0) ? '0 : regs_q[rs_a];
    assign rf_b = (rs_b == 4'd0) ? '0 : regs_q[rs_b];

`ifdef WB_BYPASS_EN
    // wb_en is never set for rd = 0, so r0 reads stay zero.
    assign rdata_a = (wb_en && rs_a == wb_rd) ? wb_data : rf_a;
    assign rdata_b = (wb_en && rs_b == wb_rd) ? wb_data : rf_b;
`else
    assign rdata_a = rf_a;
    assign rdata_b = rf_b;
`endif

    assign retired_count = cnt_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage.
// Scoreboard of post-edge counter/halt state plus a register-file model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rs_a = '0;
    logic [3:0]  rs_b = '0;
    logic [31:0] rdata_a, rdata_b;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retired_count;
    logic        halted;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_i         (bus),
        .rs_a          (rs_a),
        .rs_b          (rs_b),
        .rdata_a       (rdata_a),
        .rdata_b       (rdata_b),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .retired_count (retired_count),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic        hlt;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mreg [16];
    logic [31:0] mcnt  = '0;
    logic        mhalt = 1'b0;
    logic        armed = 1'b0;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] rd,
                       input logic [10:0] sg, input logic [31:0] alu,
                       input logic [31:0] dat, input logic [3:0] ra,
                       input logic [3:0] rb);
        exp_t        e;
        logic        en;
        logic [31:0] v, ea, eb;
        @(negedge clk);
        rst_n       = rst;
        bus.rd_in   = rd;
        bus.sign_in = sg;
        bus.alu_in  = alu;
        bus.data_in = dat;
        rs_a        = ra;
        rs_b        = rb;
        #1;
        en = rst & sg[8] & (rd != 4'd0) & ~mhalt;
        v  = sg[9] ? dat : alu;
        ea = (ra == 4'd0) ? 32'd0 : mreg[ra];
        eb = (rb == 4'd0) ? 32'd0 : mreg[rb];
`ifdef WB_BYPASS_EN
        if (en && ra == rd) ea = v;
        if (en && rb == rd) eb = v;
`endif
        check("wb_en", {31'd0, wb_en}, {31'd0, en});
        check("wb_rd", {28'd0, wb_rd}, {28'd0, rd});
        check("wb_data", wb_data, v);
        if (armed) begin
            check("rdata_a", rdata_a, ea);
            check("rdata_b", rdata_b, eb);
        end
        if (!rst) begin
            for (int i = 0; i < 16; i++) mreg[i] = '0;
            mcnt  = '0;
            mhalt = 1'b0;
        end else if (!mhalt) begin
            if (en) mreg[rd] = v;
            if (sg[8] | sg[10]) mcnt = mcnt + 32'd1;
            if (sg[10]) mhalt = 1'b1;
        end
        e.cnt = mcnt;
        e.hlt = mhalt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard empty");
        end else begin
            e = sbq.pop_front();
            check("retired_count", retired_count, e.cnt);
            check("halted", {31'd0, halted}, {31'd0, e.hlt});
        end
        if (!rst) armed = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        bus.rd_in   = '0;
        bus.sign_in = '0;
        bus.alu_in  = '0;
        bus.data_in = '0;

        cyc(1'b0, 4'd3, 11'h100, 32'd5, 32'd0, 4'd3, 4'd0);
        cyc(1'b0, 4'd3, 11'h100, 32'd5, 32'd0, 4'd3, 4'd0);

        cyc(1'b1, 4'd4, 11'h100, 32'hDEADBEEF, 32'd0, 4'd3, 4'd4);
        cyc(1'b1, 4'd7, 11'h300, 32'h1, 32'h12345678, 4'd4, 4'd0);
        cyc(1'b1, 4'd0, 11'h100, 32'hFFFFFFFF, 32'd0, 4'd7, 4'd0);
        cyc(1'b1, 4'd9, 11'h100, 32'hA5, 32'd0, 4'd9, 4'd0);
        cyc(1'b1, 4'd0, 11'h000, 32'd0, 32'd0, 4'd9, 4'd4);
        cyc(1'b1, 4'd5, 11'h0FF, 32'h55, 32'h66, 4'd5, 4'd7);

        for (int n = 0; n < 40; n++) begin
            cyc(1'b1, 4'($urandom_range(0, 15)),
                {1'b0, 1'($urandom), 1'($urandom), 8'($urandom)},
                $urandom, $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        cyc(1'b1, 4'd2, 11'h500, 32'd8, 32'd0, 4'd2, 4'd0);
        cyc(1'b1, 4'd2, 11'h100, 32'd99, 32'd0, 4'd2, 4'd7);
        cyc(1'b1, 4'd2, 11'h500, 32'd77, 32'd0, 4'd2, 4'd4);
        cyc(1'b1, 4'd6, 11'h300, 32'd1, 32'd2, 4'd2, 4'd6);

        cyc(1'b0, 4'd2, 11'h500, 32'd3, 32'd0, 4'd2, 4'd0);
        cyc(1'b1, 4'd0, 11'h000, 32'd0, 32'd0, 4'd2, 4'd9);
        cyc(1'b1, 4'd11, 11'h100, 32'hCAFE, 32'd0, 4'd11, 4'd0);
        cyc(1'b1, 4'd12, 11'h400, 32'd4, 32'd0, 4'd11, 4'd12);
        cyc(1'b0, 4'd11, 11'h100, 32'd1, 32'd0, 4'd11, 4'd0);
        cyc(1'b1, 4'd11, 11'h500, 32'd31, 32'd0, 4'd11, 4'd12);
        cyc(1'b1, 4'd0, 11'h000, 32'd0, 32'd0, 4'd11, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
